// File: rtl/moving_diff_if.sv
// Stream bundle for moving_diff: input beat (i_*) and output beat (o_*), one sample each.
// The slave modport is the comb stage itself; the master modport is whatever feeds and drains it.
interface moving_diff_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH:0]   o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/moving_diff.sv
// Streaming comb stage: y[n] = x[n] - x[n-len], exact in WIDTH+1 bits, one output register.
// The lag is latched on reset/clear; history shorter than the lag reads as zero.
module moving_diff #(
    parameter int MAX_LEN_LOG2 = 10,
    parameter int WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [MAX_LEN_LOG2-1:0] len,
    moving_diff_if.slave            bus
);
    localparam int DEPTH = 1 << MAX_LEN_LOG2;

    typedef logic [MAX_LEN_LOG2-1:0] ptr_t;

    logic [WIDTH-1:0] mem [DEPTH];

    ptr_t                len_q, len_d;
    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                fill_q, fill_d;
    logic signed [WIDTH:0] o_tdata_q, o_tdata_d;
    logic                o_tlast_q, o_tlast_d;
    logic                o_tvalid_q, o_tvalid_d;

    ptr_t                rd_ptr;
    logic                sub_en;
    logic [WIDTH-1:0]    sub;
    logic signed [WIDTH:0] diff;
    logic                accept;

    // Clear (and reset) block acceptance so a flushed cycle never writes history.
    assign bus.i_tready = ~(reset | clear) & (bus.o_tready | ~o_tvalid_q);
    assign accept       = bus.i_tvalid & bus.i_tready;

    // Pointer subtraction wraps modulo DEPTH, which is exactly the lag address.
    assign rd_ptr = wr_ptr_q - len_q;
    assign sub_en = (len_q != '0) && (fill_q >= len_q);
    assign sub    = sub_en ? mem[rd_ptr] : '0;
    assign diff   = $signed({bus.i_tdata[WIDTH-1], bus.i_tdata}) - $signed({sub[WIDTH-1], sub});

    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no branch infers a latch.
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        o_tvalid_d = o_tvalid_q;

        if (clear) begin
            len_d      = len;
            wr_ptr_d   = '0;
            fill_d     = '0;
            o_tdata_d  = '0;
            o_tlast_d  = 1'b0;
            o_tvalid_d = 1'b0;
        end else if (accept) begin
            wr_ptr_d   = wr_ptr_q + ptr_t'(1);
            if (fill_q < len_q) begin
                fill_d = fill_q + ptr_t'(1);
            end
            o_tdata_d  = diff;
            o_tlast_d  = bus.i_tlast;
            o_tvalid_d = 1'b1;
        end else if (bus.o_tready) begin
            o_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            len_q      <= len;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
        end else begin
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            o_tvalid_q <= o_tvalid_d;
        end
    end

    // NOTE: the delay line has no reset; stale entries are never read because fill_q masks them.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= bus.i_tdata;
        end
    end

    assign bus.o_tdata  = o_tdata_q;
    assign bus.o_tlast  = o_tlast_q;
    assign bus.o_tvalid = o_tvalid_q;
endmodule

// File: tb/tb_moving_diff.sv
// Directed and backpressured stimulus for moving_diff, scored against a history-based model
// plus hand-computed spot values for each scenario.
module tb_moving_diff;
    localparam int LOG2 = 10;
    localparam int W    = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic [LOG2-1:0] len;

    moving_diff_if #(.WIDTH(W)) bus ();

    moving_diff #(.MAX_LEN_LOG2(LOG2), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .len   (len),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } beat_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    hist[$];
    beat_t exp_q[$];
    int    got_q[$];
    int    len_m;
    bit    last_acc;
    string phase;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, then account for what the next rising edge will do.
    task automatic cycle(input bit v, input int d, input bit l, input bit rdy, input bit clr, input bit rst);
        beat_t   e;
        shortint xs;
        int      n;
        @(negedge clk);
        bus.i_tvalid = v;
        bus.i_tdata  = W'(d);
        bus.i_tlast  = l;
        bus.o_tready = rdy;
        clear        = clr;
        reset        = rst;
        #1;
        last_acc = 1'b0;
        if (rst || clr) begin
            hist.delete();
            exp_q.delete();
            len_m = int'(len);
        end else begin
            if (bus.o_tvalid && bus.o_tready) begin
                got_q.push_back(int'($signed(bus.o_tdata)));
                if (exp_q.size() == 0) begin
                    check({phase, "_extra"}, bus.o_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({phase, "_data"}, $signed(bus.o_tdata), e.data);
                    check({phase, "_last"}, bus.o_tlast, e.last);
                end
            end
            if (bus.i_tvalid && bus.i_tready) begin
                last_acc = 1'b1;
                xs       = shortint'(d);
                n        = hist.size();
                e.data   = (len_m != 0 && n >= len_m) ? int'(xs) - hist[n - len_m] : int'(xs);
                e.last   = l;
                hist.push_back(int'(xs));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic feed(input int d, input bit l);
        for (int t = 0; t < 16; t++) begin
            cycle(1'b1, d, l, 1'b1, 1'b0, 1'b0);
            if (last_acc) return;
        end
        check({phase, "_stall"}, last_acc, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 16 && exp_q.size() != 0; t++) begin
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check({phase, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic do_clear(input int l);
        drain();
        len = LOG2'(l);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        got_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int      k;
        int      cyc;
        int      ms;
        int      d;
        bit      l;
        shortint sv;
        int      xs_q[$];

        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.o_tready = 1'b0;
        clear        = 1'b0;
        reset        = 1'b1;
        len          = LOG2'(20);

        phase = "reset";
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("rst_vld", bus.o_tvalid, 0);
        check("rst_data", $signed(bus.o_tdata), 0);
        check("rst_last", bus.o_tlast, 0);

        // Constant 1 with lag 20: twenty ones, then zeros.
        phase = "const";
        got_q.delete();
        cycle(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("first_rdy", bus.i_tready, 1);
        check("first_vld_pre", bus.o_tvalid, 0);
        @(posedge clk); #1;
        check("first_vld", bus.o_tvalid, 1);
        for (int i = 1; i < 60; i++) feed(1, 1'b0);
        drain();
        check("const_cnt", got_q.size(), 60);
        foreach (got_q[i]) check("const_hand", got_q[i], (i < 20) ? 1 : 0);

        // Moving sum (20 taps) of a ramp, differenced at lag 20: settles at 20*20 = 400.
        phase = "rtrip";
        do_clear(20);
        for (int n = 0; n < 200; n++) begin
            ms = 0;
            for (int j = (n >= 19 ? n - 19 : 0); j <= n; j++) ms += j;
            feed(ms, (n % 50) == 49);
        end
        drain();
        check("rtrip_19", got_q[19], 190);
        check("rtrip_20", got_q[20], 210);
        check("rtrip_199", got_q[199], 400);

        // Full-scale alternation at lag 1 needs the 17th bit.
        phase = "ext";
        do_clear(1);
        for (int i = 0; i < 8; i++) feed((i % 2) ? 32767 : -32768, 1'b0);
        drain();
        foreach (got_q[i]) check("ext_hand", got_q[i], (i == 0) ? -32768 : ((i % 2) ? 65535 : -65535));

        // A len change without clear is ignored; clear latches it and blocks the same-cycle beat.
        phase = "lenchg";
        do_clear(20);
        for (int i = 0; i < 100; i++) feed(i * 3 - 150, 1'b0);
        len = LOG2'(5);
        for (int i = 0; i < 30; i++) feed(i * 11, (i % 4) == 0);
        drain();
        cycle(1'b1, 77, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_rdy", bus.i_tready, 0);
        @(posedge clk); #1;
        check("clr_vld", bus.o_tvalid, 0);
        got_q.delete();
        for (int i = 0; i < 20; i++) feed(i * i, 1'b0);
        drain();
        foreach (got_q[i]) check("lag5_hand", got_q[i], (i < 5) ? i * i : 10 * i - 25);

        // Lag 0 is a sign-extending pass-through.
        phase = "len0";
        do_clear(0);
        for (int i = 0; i < 16; i++) feed(i * 4099 - 32768, 1'b0);
        drain();
        foreach (got_q[i]) check("len0_hand", got_q[i], i * 4099 - 32768);

        // Random valid/ready, lag 37, enough beats for five pointer wraps.
        phase = "rand";
        do_clear(37);
        k   = 0;
        cyc = 0;
        sv  = shortint'($urandom);
        d   = int'(sv);
        l   = ($urandom_range(0, 3) == 0);
        while (k < 5500 && cyc < 40000) begin
            cycle(1'($urandom_range(0, 1)), d, l, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (last_acc) begin
                k++;
                sv = shortint'($urandom);
                d  = int'(sv);
                l  = ($urandom_range(0, 3) == 0);
            end
            cyc++;
        end
        check("rand_cnt", k, 5500);
        drain();

        // Maximum lag.
        phase = "len1023";
        do_clear(1023);
        xs_q.delete();
        for (int i = 0; i < 3000; i++) begin
            sv = shortint'($urandom);
            xs_q.push_back(int'(sv));
            feed(int'(sv), (i % 100) == 99);
        end
        drain();
        check("max_1022", got_q[1022], xs_q[1022]);
        check("max_1023", got_q[1023], xs_q[1023] - xs_q[0]);
        check("max_2999", got_q[2999], xs_q[2999] - xs_q[1976]);

        // Reset with a beat still waiting in the output register.
        phase = "midrst";
        do_clear(20);
        for (int i = 0; i < 30; i++) feed(500 + i, 1'b0);
        cycle(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("rst_mid_vld", bus.o_tvalid, 0);
        got_q.delete();
        for (int i = 0; i < 25; i++) feed(1000 + i, 1'b0);
        drain();
        check("midrst_cnt", got_q.size(), 25);
        foreach (got_q[i]) check("midrst_hand", got_q[i], (i < 20) ? 1000 + i : 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
